// File: rtl/control_unit.sv
// Fetch/execute sequencer for the Datapath: one state per clock, decodes IR[31:27].
// Ports: Clock/Clear (async high), IR, Stop in; Run, bus drives, load enables, gates, IncPC, Read, CONTROL out.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        C_Out,
    output logic        R_Out,
    output logic        BA_Out,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        MAR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        R_In,
    output logic        G_RA,
    output logic        G_RB,
    output logic        G_RC,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  CONTROL
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b01000;
    localparam logic [4:0] ALU_OR  = 5'b01001;

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_T0, S_T1, S_T2,
        S_T3, S_T4, S_T5, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] opc;
    logic       is_r;
    logic       is_i;
    logic [4:0] alu_code;

    assign opc = IR[31:27];

    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        alu_code = 5'b00000;
        case (opc)
            OP_ADD:  begin is_r = 1'b1; alu_code = ALU_ADD; end
            OP_SUB:  begin is_r = 1'b1; alu_code = ALU_SUB; end
            OP_AND:  begin is_r = 1'b1; alu_code = ALU_AND; end
            OP_OR:   begin is_r = 1'b1; alu_code = ALU_OR;  end
            OP_ADDI: begin is_i = 1'b1; alu_code = ALU_ADD; end
            OP_ANDI: begin is_i = 1'b1; alu_code = ALU_AND; end
            OP_ORI:  begin is_i = 1'b1; alu_code = ALU_OR;  end
            default: ;
        endcase
    end

    // Stop is only honoured at instruction boundaries.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RESET;
        end else begin
            unique case (state)
                S_RESET: state <= Stop ? S_IDLE : S_T0;
                S_IDLE:  state <= Stop ? S_IDLE : S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3: begin
                    if (is_r || is_i)
                        state <= S_T4;
                    else if (opc == OP_HALT)
                        state <= S_HALT;
                    else
                        state <= Stop ? S_IDLE : S_T0;
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= Stop ? S_IDLE : S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    // Outputs follow the state directly, so an async Clear kills them at once.
    always_comb begin
        Run     = 1'b0;
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        C_Out   = 1'b0;
        R_Out   = 1'b0;
        BA_Out  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        R_In    = 1'b0;
        G_RA    = 1'b0;
        G_RB    = 1'b0;
        G_RC    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = 5'b00000;
        case (state)
            S_T0: begin
                Run    = 1'b1;
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
            end
            S_T1: begin
                Run    = 1'b1;
                Read   = 1'b1;
                MDR_In = 1'b1;
            end
            S_T2: begin
                Run     = 1'b1;
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_r || is_i) begin
                    G_RB   = 1'b1;
                    Y_In   = 1'b1;
                    R_Out  = is_r;
                    BA_Out = is_i;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (is_r || is_i) begin
                    ZLO_In  = 1'b1;
                    CONTROL = alu_code;
                    G_RC    = is_r;
                    R_Out   = is_r;
                    C_Out   = is_i;
                end
            end
            S_T5: begin
                Run     = 1'b1;
                ZLO_Out = 1'b1;
                G_RA    = 1'b1;
                R_In    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-scenario tasks with inline checks.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_control_unit;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
    logic        Run;
    logic        PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In;
    logic        G_RA, G_RB, G_RC, IncPC, Read;
    logic [4:0]  CONTROL;

    int checks = 0;
    int fails  = 0;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .Run(Run),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out),
        .C_Out(C_Out), .R_Out(R_Out), .BA_Out(BA_Out),
        .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In),
        .Y_In(Y_In), .ZLO_In(ZLO_In), .R_In(R_In),
        .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC),
        .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    logic [23:0] obs;
    assign obs = {Run, PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out,
                  PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In,
                  G_RA, G_RB, G_RC, IncPC, Read, CONTROL};

    localparam logic [23:0] M_RUN  = 24'd1 << 23;
    localparam logic [23:0] M_PCO  = 24'd1 << 22;
    localparam logic [23:0] M_MDRO = 24'd1 << 21;
    localparam logic [23:0] M_ZLOO = 24'd1 << 20;
    localparam logic [23:0] M_CO   = 24'd1 << 19;
    localparam logic [23:0] M_RO   = 24'd1 << 18;
    localparam logic [23:0] M_BAO  = 24'd1 << 17;
    localparam logic [23:0] M_MDRI = 24'd1 << 15;
    localparam logic [23:0] M_MARI = 24'd1 << 14;
    localparam logic [23:0] M_IRI  = 24'd1 << 13;
    localparam logic [23:0] M_YI   = 24'd1 << 12;
    localparam logic [23:0] M_ZLOI = 24'd1 << 11;
    localparam logic [23:0] M_RI   = 24'd1 << 10;
    localparam logic [23:0] M_GRA  = 24'd1 << 9;
    localparam logic [23:0] M_GRB  = 24'd1 << 8;
    localparam logic [23:0] M_GRC  = 24'd1 << 7;
    localparam logic [23:0] M_INC  = 24'd1 << 6;
    localparam logic [23:0] M_RD   = 24'd1 << 5;

    localparam logic [23:0] E_ZERO = 24'h000000;
    localparam logic [23:0] E_T0  = M_RUN | M_PCO | M_MARI | M_INC;
    localparam logic [23:0] E_T1  = M_RUN | M_RD | M_MDRI;
    localparam logic [23:0] E_T2  = M_RUN | M_MDRO | M_IRI;
    localparam logic [23:0] E_T3R = M_RUN | M_GRB | M_RO | M_YI;
    localparam logic [23:0] E_T3I = M_RUN | M_GRB | M_BAO | M_YI;
    localparam logic [23:0] E_T3N = M_RUN;
    localparam logic [23:0] E_T4R = M_RUN | M_GRC | M_RO | M_ZLOI;
    localparam logic [23:0] E_T4I = M_RUN | M_CO | M_ZLOI;
    localparam logic [23:0] E_T5  = M_RUN | M_ZLOO | M_GRA | M_RI;

    localparam logic [31:0] IR_ANDI = 32'h6108001A;
    localparam logic [31:0] IR_ADD  = {5'b00011, 27'h0443000};
    localparam logic [31:0] IR_SUB  = {5'b00100, 27'h0100000};
    localparam logic [31:0] IR_OR   = {5'b00110, 27'h0200000};
    localparam logic [31:0] IR_ORI  = {5'b01101, 27'h00000FF};
    localparam logic [31:0] IR_UND  = {5'b11111, 27'h0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'h0};

    // Bus drives must never overlap.
    always @(negedge Clock) begin
        checks++;
        assert ($onehot0({PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out}))
        else begin
            fails++;
            $display("FAIL bus_onehot: drives=%b required at most one high",
                     {PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset;
        Clear = 1'b1;
        Stop  = 1'b1;
        IR    = 32'h0;
        @(negedge Clock);
        #1;
        checks++;
        if (obs !== E_ZERO) begin
            fails++;
            $display("FAIL reset: got %h required %h", obs, E_ZERO);
        end
        Clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== E_ZERO) begin
                fails++;
                $display("FAIL idle_%0d: got %h required %h", i, obs, E_ZERO);
            end
        end
        Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== E_T0) begin
            fails++;
            $display("FAIL idle_exit: got %h required %h", obs, E_T0);
        end
    endtask

    task automatic test_andi;
        logic [23:0] seq [7];
        seq = '{E_T0, E_T1, E_T2, E_T3I, E_T4I | 24'h8, E_T5, E_T0};
        IR = IR_ANDI;
        Clear = 1'b1;
        #1;
        Clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL andi_t%0d: got %h required %h", i % 6, obs, seq[i]);
            end
        end
    endtask

    task automatic test_add;
        logic [23:0] seq [6];
        seq = '{E_T1, E_T2, E_T3R, E_T4R | 24'h3, E_T5, E_T0};
        IR = IR_ADD;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL add_t%0d: got %h required %h", (i + 1) % 6, obs, seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] irs [3];
        logic [23:0] t3  [3];
        logic [23:0] t4  [3];
        logic [23:0] seq [6];
        irs = '{IR_SUB, IR_OR, IR_ORI};
        t3  = '{E_T3R, E_T3R, E_T3I};
        t4  = '{E_T4R | 24'h04, E_T4R | 24'h09, E_T4I | 24'h09};
        for (int n = 0; n < 3; n++) begin
            IR = irs[n];
            seq = '{E_T1, E_T2, t3[n], t4[n], E_T5, E_T0};
            for (int i = 0; i < 6; i++) begin
                @(posedge Clock);
                @(negedge Clock);
                checks++;
                if (obs !== seq[i]) begin
                    fails++;
                    $display("FAIL b2b%0d_t%0d: got %h required %h",
                             n, (i + 1) % 6, obs, seq[i]);
                end
            end
        end
    endtask

    task automatic test_undefined;
        logic [23:0] seq [4];
        seq = '{E_T1, E_T2, E_T3N, E_T0};
        IR = IR_UND;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL undef_t%0d: got %h required %h", (i + 1) % 4, obs, seq[i]);
            end
        end
    endtask

    task automatic test_stop;
        logic [23:0] seq [7];
        seq = '{E_T1, E_T2, E_T3I, E_T4I | 24'h8, E_T5, E_ZERO, E_ZERO};
        IR = IR_ANDI;
        for (int i = 0; i < 7; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL stop_step%0d: got %h required %h", i, obs, seq[i]);
            end
            if (i == 1)
                Stop = 1'b1;
        end
        Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== E_T0) begin
            fails++;
            $display("FAIL stop_resume: got %h required %h", obs, E_T0);
        end
    endtask

    task automatic test_clear_mid;
        logic [23:0] seq [4];
        seq = '{E_T1, E_T2, E_T3I, E_T4I | 24'h8};
        IR = IR_ANDI;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL clrmid_t%0d: got %h required %h", i + 1, obs, seq[i]);
            end
        end
        #2;
        Clear = 1'b1;
        #1;
        checks++;
        if (obs !== E_ZERO) begin
            fails++;
            $display("FAIL clrmid_async: got %h required %h", obs, E_ZERO);
        end
        @(negedge Clock);
        Clear = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== E_T0) begin
            fails++;
            $display("FAIL clrmid_t0: got %h required %h", obs, E_T0);
        end
    endtask

    task automatic test_halt;
        logic [23:0] seq [3];
        seq = '{E_T1, E_T2, E_T3N};
        IR = IR_HALT;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== seq[i]) begin
                fails++;
                $display("FAIL halt_t%0d: got %h required %h", i + 1, obs, seq[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs !== E_ZERO) begin
                fails++;
                $display("FAIL halted_%0d: got %h required %h", i, obs, E_ZERO);
            end
        end
        Clear = 1'b1;
        #1;
        checks++;
        if (obs !== E_ZERO) begin
            fails++;
            $display("FAIL halt_clear: got %h required %h", obs, E_ZERO);
        end
        IR = IR_ADD;
        Clear = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs !== E_T0) begin
            fails++;
            $display("FAIL halt_restart: got %h required %h", obs, E_T0);
        end
    endtask

    initial begin
        Clear = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h0;
        test_reset();
        test_andi();
        test_add();
        test_back_to_back();
        test_undefined();
        test_stop();
        test_halt();
        test_clear_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
